// File: rtl/rv32v_writeback_queue.sv
// rv32v_writeback_queue
// Buffers vector execute results in a small FIFO ahead of the vector register
// file write port. At most one entry drains per cycle. Decode sees a hazard
// flag for any source register that still has a write pending in the queue.

module rv32v_writeback_queue #(
  parameter int NUM_LANES = 2,
  parameter int WEN_WIDTH = 4,
  parameter int DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [4:0]                ex_vd,
  input  logic [NUM_LANES*32-1:0]   ex_data,
  input  logic [NUM_LANES-1:0]      ex_lane_en,
  input  logic                      flush,
  input  logic                      rf_ready,
  output logic [NUM_LANES*32-1:0]   w_data,
  output logic [4:0]                rd,
  output logic [WEN_WIDTH-1:0]      wen,
  input  logic [4:0]                dec_rs1,
  input  logic [4:0]                dec_rs2,
  output logic                      hazard_rs1,
  output logic                      hazard_rs2,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]              r_vd   [DEPTH];
  logic [NUM_LANES*32-1:0] r_data [DEPTH];
  logic [NUM_LANES-1:0]    r_en   [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_haz1;
  logic w_haz2;

  // ex_ready looks only at fullness, so a full queue refuses input even on a
  // cycle where it also drains. A zero-mask result completes the handshake
  // but never occupies a slot. Flush blocks both pushes and pops.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign ex_ready = !w_full;
  assign w_accept = ex_valid && ex_ready && !flush;
  assign w_push   = w_accept && (|ex_lane_en);
  assign w_pop    = !w_empty && rf_ready && !flush;
  assign count    = r_count;

  // Pointer and occupancy bookkeeping; flush empties the queue on the next edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset because the outputs are gated by occupancy.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_vd[r_tail]   <= ex_vd;
      r_data[r_tail] <= ex_data;
      r_en[r_tail]   <= ex_lane_en;
    end
  end

  // Present the head entry to the register file, or all zeros when idle or flushing.
  always_comb begin
    rd     = '0;
    w_data = '0;
    wen    = '0;
    if (!w_empty && !flush) begin
      rd     = r_vd[r_head];
      w_data = r_data[r_head];
      wen    = WEN_WIDTH'(r_en[r_head]);
    end
  end

  // Scan occupied slots and the incoming result for pending writes to the decode sources.
  always_comb begin
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (|r_en[r_head + PW'(i)])) begin
        if (r_vd[r_head + PW'(i)] == dec_rs1) begin
          w_haz1 = 1'b1;
        end
        if (r_vd[r_head + PW'(i)] == dec_rs2) begin
          w_haz2 = 1'b1;
        end
      end
    end
    if (w_push && (ex_vd == dec_rs1)) begin
      w_haz1 = 1'b1;
    end
    if (w_push && (ex_vd == dec_rs2)) begin
      w_haz2 = 1'b1;
    end
    if (flush) begin
      w_haz1 = 1'b0;
      w_haz2 = 1'b0;
    end
  end

  assign hazard_rs1 = w_haz1;
  assign hazard_rs2 = w_haz2;

endmodule

// File: tb/tb_rv32v_writeback_queue.sv
// tb_rv32v_writeback_queue
// Directed checks of the writeback queue: single write, fill/backpressure,
// wraparound with simultaneous push/pop, hazards, zero mask, flush and reset.

module tb_rv32v_writeback_queue;

  logic        CLK;
  logic        RST;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_vd;
  logic [63:0] ex_data;
  logic [1:0]  ex_lane_en;
  logic        flush;
  logic        rf_ready;
  logic [63:0] w_data;
  logic [4:0]  rd;
  logic [3:0]  wen;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic [2:0]  count;

  int testCount = 0;
  int failCount = 0;

  rv32v_writeback_queue #(
    .NUM_LANES(2),
    .WEN_WIDTH(4),
    .DEPTH(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_vd(ex_vd),
    .ex_data(ex_data),
    .ex_lane_en(ex_lane_en),
    .flush(flush),
    .rf_ready(rf_ready),
    .w_data(w_data),
    .rd(rd),
    .wen(wen),
    .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2),
    .hazard_rs1(hazard_rs1),
    .hazard_rs2(hazard_rs2),
    .count(count)
  );

  // Free-running 10-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] vd, input logic [63:0] data,
                               input logic [1:0] en, input logic rf);
    ex_valid   = v;
    ex_vd      = vd;
    ex_data    = data;
    ex_lane_en = en;
    rf_ready   = rf;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Directed sequence; inputs change 1 unit after the rising edge, outputs are checked 1 unit later.
  initial begin
    logic [4:0]  fillVd   [4];
    logic [63:0] fillData [4];
    logic [1:0]  fillEn   [4];
    int          q[$];
    int          sent;
    int          cyc;
    logic        expReady;

    fillVd[0] = 5'd1; fillData[0] = 64'h00000010_00000001; fillEn[0] = 2'b01;
    fillVd[1] = 5'd2; fillData[1] = 64'h00000020_00000002; fillEn[1] = 2'b10;
    fillVd[2] = 5'd3; fillData[2] = 64'h00000030_00000003; fillEn[2] = 2'b11;
    fillVd[3] = 5'd4; fillData[3] = 64'h00000040_00000004; fillEn[3] = 2'b01;

    RST = 1'b1;
    flush = 1'b0;
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_count", 64'(count), 64'd0);
    checkOutput("reset_wen", 64'(wen), 64'd0);
    checkOutput("reset_rd", 64'(rd), 64'd0);
    checkOutput("reset_wdata", w_data, 64'd0);
    checkOutput("reset_ready", 64'(ex_ready), 64'd1);
    checkOutput("reset_haz1", 64'(hazard_rs1), 64'd0);
    RST = 1'b0;
    tick();

    // Single write: no same-cycle bypass, visible next cycle, then drained.
    applyStimulus(1'b1, 5'd5, {32'hA, 32'hB}, 2'b11, 1'b1);
    #1;
    checkOutput("single_no_bypass", 64'(wen), 64'd0);
    checkOutput("single_ready", 64'(ex_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b1);
    #1;
    checkOutput("single_rd", 64'(rd), 64'd5);
    checkOutput("single_wen", 64'(wen), 64'h3);
    checkOutput("single_wdata", w_data, 64'h0000000A_0000000B);
    checkOutput("single_count", 64'(count), 64'd1);
    tick();
    checkOutput("single_drained", 64'(count), 64'd0);
    checkOutput("single_wen_idle", 64'(wen), 64'd0);

    // Fill with the RF stalled, then check backpressure.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillVd[i], fillData[i], fillEn[i], 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b0);
    #1;
    checkOutput("fill_count", 64'(count), 64'd4);
    checkOutput("fill_ready", 64'(ex_ready), 64'd0);
    applyStimulus(1'b1, 5'd20, 64'hDEAD, 2'b11, 1'b0);
    #1;
    checkOutput("fill_5th_ready", 64'(ex_ready), 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b0);
    #1;
    checkOutput("fill_5th_held", 64'(count), 64'd4);
    checkOutput("fill_head", 64'(rd), 64'd1);

    // Full queue refuses input even while it pops.
    applyStimulus(1'b1, 5'd21, 64'hBEEF, 2'b11, 1'b1);
    #1;
    checkOutput("full_pop_ready", 64'(ex_ready), 64'd0);
    checkOutput("full_pop_rd", 64'(rd), 64'd1);
    checkOutput("full_pop_wen", 64'(wen), 64'h1);
    checkOutput("full_pop_wdata", w_data, fillData[0]);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b1);
    #1;
    checkOutput("full_pop_count", 64'(count), 64'd3);
    for (int i = 1; i < 4; i++) begin
      checkOutput("drain_rd", 64'(rd), 64'(fillVd[i]));
      checkOutput("drain_wen", 64'(wen), 64'(fillEn[i]));
      checkOutput("drain_wdata", w_data, fillData[i]);
      tick();
    end
    checkOutput("drain_empty", 64'(count), 64'd0);
    checkOutput("drain_wen_idle", 64'(wen), 64'd0);

    // Hazard tracking on an incoming, queued and popping entry.
    applyStimulus(1'b1, 5'd7, 64'h77, 2'b01, 1'b0);
    dec_rs1 = 5'd7;
    dec_rs2 = 5'd3;
    #1;
    checkOutput("haz_incoming_rs1", 64'(hazard_rs1), 64'd1);
    checkOutput("haz_incoming_rs2", 64'(hazard_rs2), 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b0);
    #1;
    checkOutput("haz_queued_rs1", 64'(hazard_rs1), 64'd1);
    checkOutput("haz_queued_rs2", 64'(hazard_rs2), 64'd0);
    rf_ready = 1'b1;
    #1;
    checkOutput("haz_popping_rs1", 64'(hazard_rs1), 64'd1);
    checkOutput("haz_popping_wen", 64'(wen), 64'h1);
    tick();
    checkOutput("haz_cleared_rs1", 64'(hazard_rs1), 64'd0);
    checkOutput("haz_cleared_count", 64'(count), 64'd0);

    // Zero lane mask: handshake completes but nothing is stored.
    applyStimulus(1'b1, 5'd9, 64'h99, 2'b00, 1'b1);
    dec_rs1 = 5'd9;
    #1;
    checkOutput("zmask_ready", 64'(ex_ready), 64'd1);
    checkOutput("zmask_haz_in", 64'(hazard_rs1), 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b1);
    #1;
    checkOutput("zmask_count", 64'(count), 64'd0);
    checkOutput("zmask_wen", 64'(wen), 64'd0);
    checkOutput("zmask_haz", 64'(hazard_rs1), 64'd0);

    // Flush with three entries queued and a result arriving the same cycle.
    dec_rs1 = 5'd1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, fillVd[i], fillData[i], 2'b11, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 5'd4, 64'h44, 2'b11, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("flush_wen", 64'(wen), 64'd0);
    checkOutput("flush_haz", 64'(hazard_rs1), 64'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b1);
    #1;
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_wen_after", 64'(wen), 64'd0);
    checkOutput("flush_haz_after", 64'(hazard_rs1), 64'd0);

    // Same sequence with an asynchronous reset instead of flush.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, fillVd[i], fillData[i], 2'b11, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b0);
    #1;
    checkOutput("rst_pre_count", 64'(count), 64'd3);
    applyStimulus(1'b1, 5'd4, 64'h44, 2'b11, 1'b1);
    RST = 1'b1;
    #1;
    checkOutput("rst_async_count", 64'(count), 64'd0);
    checkOutput("rst_async_wen", 64'(wen), 64'd0);
    tick();
    RST = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b1);
    #1;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_wen", 64'(wen), 64'd0);
    checkOutput("rst_ready", 64'(ex_ready), 64'd1);
    checkOutput("rst_haz", 64'(hazard_rs1), 64'd0);
    tick();

    // Ten back-to-back writes with rf_ready toggling, tracked by a reference queue.
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    sent = 0;
    cyc = 0;
    while ((sent < 10 || q.size() > 0) && cyc < 60) begin
      expReady = (q.size() < 4);
      applyStimulus(sent < 10, 5'(10 + sent), {32'(sent), ~32'(sent)}, 2'b11, (cyc % 2) == 0);
      #1;
      checkOutput("wrap_count", 64'(count), 64'(q.size()));
      checkOutput("wrap_ready", 64'(ex_ready), 64'(expReady));
      if (q.size() > 0) begin
        checkOutput("wrap_rd", 64'(rd), 64'(10 + q[0]));
        checkOutput("wrap_wdata", w_data, {32'(q[0]), ~32'(q[0])});
      end else begin
        checkOutput("wrap_wen_idle", 64'(wen), 64'd0);
      end
      tick();
      if (q.size() > 0 && (cyc % 2) == 0) begin
        void'(q.pop_front());
      end
      if (sent < 10 && expReady) begin
        q.push_back(sent);
        sent++;
      end
      cyc++;
    end
    checkOutput("wrap_within_budget", 64'(cyc < 60), 64'd1);
    applyStimulus(1'b0, 5'd0, 64'h0, 2'b00, 1'b1);
    #1;
    checkOutput("wrap_final_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
